is_array_sequencer: RTL and testbench

IS_ARRAY_SEQUENCER -- requirements
Module: is_array_sequencer

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/is_array_sequencer.sv | 178 +++++++++++++++++
 tb/tb_is_array_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array control blocks.
//   seq_state_e     : sequencer FSM states
//   default_latency : weight-in to psum-out step count of an H x W array
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } seq_state_e;

  // A weight vector must ripple down every row and across every column
  // before its (unskewed) psum vector is complete.
  function automatic int default_latency(input int height, input int width);
    return height + width;
  endfunction

endpackage

// File: rtl/is_array_sequencer.sv
// Sequencer for an input-stationary systolic array.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   start, num_vectors, busy, done   : job control (done is a 1-cycle pulse)
//   in_valid/in_ready/in_data        : input columns, loaded into the array first
//   w_valid/w_ready/w_data           : weight vectors streamed through the array
//   arr_process_en/arr_input_en/
//   arr_input_in/arr_weight_in       : drive to the array
//   arr_psum_out                     : unskewed array result
//   out_valid/out_ready/out_data     : result stream, one beat per weight vector
module is_array_sequencer
  import systolic_pkg::*;
#(
  parameter int INPUT_WIDTH  = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int PSUM_WIDTH   = 16,
  parameter int ARRAY_HEIGHT = 16,
  parameter int ARRAY_WIDTH  = 16,
  parameter int LATENCY      = default_latency(ARRAY_HEIGHT, ARRAY_WIDTH),
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [CNT_WIDTH-1:0]                      num_vectors,
  output logic                                      busy,
  output logic                                      done,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [ARRAY_HEIGHT-1:0][INPUT_WIDTH-1:0]  in_data,
  input  logic                                      w_valid,
  output logic                                      w_ready,
  input  logic [ARRAY_WIDTH-1:0][WEIGHT_WIDTH-1:0]  w_data,
  output logic                                      arr_process_en,
  output logic                                      arr_input_en,
  output logic [ARRAY_HEIGHT-1:0][INPUT_WIDTH-1:0]  arr_input_in,
  output logic [ARRAY_WIDTH-1:0][WEIGHT_WIDTH-1:0]  arr_weight_in,
  input  logic [ARRAY_WIDTH-1:0][PSUM_WIDTH-1:0]    arr_psum_out,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [ARRAY_WIDTH-1:0][PSUM_WIDTH-1:0]    out_data
);

  localparam int LCW = $clog2(ARRAY_WIDTH + 1);

  seq_state_e                                state_q, state_d;
  logic [CNT_WIDTH-1:0]                      num_q, num_d;
  logic [CNT_WIDTH-1:0]                      vec_cnt_q, vec_cnt_d;
  logic [LCW-1:0]                            load_cnt_q, load_cnt_d;
  logic [LATENCY-1:0]                        tags_q, tags_d;
  logic                                      out_valid_q, out_valid_d;
  logic [ARRAY_WIDTH-1:0][PSUM_WIDTH-1:0]    out_data_q, out_data_d;

  logic out_free;
  logic step;
  logic capture;
  logic last_col;
  logic last_vec;

  // The array only advances when the output register can take whatever
  // emerges this step, so a stalled consumer freezes the whole pipe.
  assign out_free = !out_valid_q || out_ready;
  assign step     = out_free && ((state_q == DRAIN) || ((state_q == STREAM) && w_valid));
  // Tag bit LATENCY-1 marks the step on which a real (non-drain) psum is present.
  assign capture  = step && tags_q[LATENCY-1];
  assign last_col = (load_cnt_q == LCW'(ARRAY_WIDTH - 1));
  assign last_vec = ((vec_cnt_q + CNT_WIDTH'(1)) == num_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_q       <= '0;
      vec_cnt_q   <= '0;
      load_cnt_q  <= '0;
      tags_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      vec_cnt_q   <= vec_cnt_d;
      load_cnt_q  <= load_cnt_d;
      tags_q      <= tags_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    num_d         = num_q;
    vec_cnt_d     = vec_cnt_q;
    load_cnt_d    = load_cnt_q;
    tags_d        = tags_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    in_ready      = 1'b0;
    w_ready       = 1'b0;
    arr_input_en  = 1'b0;
    arr_input_in  = '0;
    arr_weight_in = '0;

    // Output register: a capture refills it even while the old beat is
    // being handed off in the same cycle.
    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = arr_psum_out;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // A step in STREAM always accepts a weight vector (tag 1); in DRAIN
    // a bubble (tag 0) follows the real vectors through.
    if (step) begin
      tags_d = (tags_q << 1) | LATENCY'(state_q == STREAM);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_d      = num_vectors;
          vec_cnt_d  = '0;
          load_cnt_d = '0;
          state_d    = LOAD;
        end
      end

      LOAD: begin
        in_ready     = 1'b1;
        arr_input_en = in_valid;
        arr_input_in = in_data;
        if (in_valid) begin
          if (last_col) begin
            load_cnt_d = '0;
            state_d    = (num_q == '0) ? DONE : STREAM;
          end else begin
            load_cnt_d = load_cnt_q + LCW'(1);
          end
        end
      end

      STREAM: begin
        w_ready       = step;
        arr_weight_in = w_data;
        if (step) begin
          if (last_vec) begin
            vec_cnt_d = '0;
            state_d   = DRAIN;
          end else begin
            vec_cnt_d = vec_cnt_q + CNT_WIDTH'(1);
          end
        end
      end

      DRAIN: begin
        // Finish only once no result is in flight and the last beat is
        // leaving (or gone), so done never precedes the final handshake.
        if ((tags_q == '0) && out_free) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign arr_process_en = step;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;

endmodule

// File: tb/tb_is_array_sequencer.sv
module tb_is_array_sequencer;

  localparam int AH  = 4;
  localparam int AW  = 4;
  localparam int DW  = 16;
  localparam int LAT = 8;
  localparam int CW  = 16;

  typedef logic [AW-1:0][DW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_vectors;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic          in_ready;
  logic [AH-1:0][DW-1:0] in_data;
  logic          w_valid;
  logic          w_ready;
  vec_t          w_data;
  logic          arr_process_en;
  logic          arr_input_en;
  logic [AH-1:0][DW-1:0] arr_input_in;
  vec_t          arr_weight_in;
  vec_t          arr_psum_out;
  logic          out_valid;
  logic          out_ready;
  vec_t          out_data;

  is_array_sequencer #(
    .INPUT_WIDTH (DW),
    .WEIGHT_WIDTH(DW),
    .PSUM_WIDTH  (DW),
    .ARRAY_HEIGHT(AH),
    .ARRAY_WIDTH (AW),
    .LATENCY     (LAT),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_vectors   (num_vectors),
    .busy          (busy),
    .done          (done),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w_data        (w_data),
    .arr_process_en(arr_process_en),
    .arr_input_en  (arr_input_en),
    .arr_input_in  (arr_input_in),
    .arr_weight_in (arr_weight_in),
    .arr_psum_out  (arr_psum_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural array: loaded columns + LAT-step pipe
  logic [AW-1:0][AH-1:0][DW-1:0] mat_q;
  logic [1:0]                    ld_idx_q;
  vec_t                          pipe_q [LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_q    <= '0;
      ld_idx_q <= '0;
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      if (arr_input_en) begin
        mat_q[ld_idx_q] <= arr_input_in;
        ld_idx_q        <= ld_idx_q + 2'd1;
      end
      if (arr_process_en) begin
        pipe_q[0] <= arr_weight_in;
        for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  function automatic vec_t array_result(input logic [AW-1:0][AH-1:0][DW-1:0] m, input vec_t w);
    vec_t r;
    logic [DW-1:0] acc;
    for (int c = 0; c < AW; c++) begin
      acc = '0;
      for (int k = 0; k < AH; k++) acc = acc + DW'(m[c][k] * w[k]);
      r[c] = acc;
    end
    return r;
  endfunction

  assign arr_psum_out = array_result(mat_q, pipe_q[LAT-1]);

  // ---------------- consumer back-pressure
  int stall_left = 0;
  bit stall_arm  = 0;
  always @(posedge clk) begin
    #1;
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = 1'b1;
    end
  end
  always @(negedge clk) begin
    if (stall_arm && out_valid) begin
      stall_arm  = 0;
      stall_left = 5;
    end
  end

  // ---------------- scoreboard / monitor
  vec_t exp_q[$];
  int   n_results    = 0;
  int   n_valid_seen = 0;
  int   n_step_seen  = 0;
  int   n_stall      = 0;
  int   n_done       = 0;
  int   last_hs_cyc  = -10;
  bit   prev_stall   = 0;
  vec_t held_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, held_data);
      end
      prev_stall = out_valid && !out_ready;
      held_data  = out_data;
      if (out_valid && !out_ready) begin
        n_stall++;
        check("stall_no_step", arr_process_en, 1'b0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_result", 1'b1, 1'b0);
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          check("result", out_data, e);
        end
        $display("[%0d] result %0d data=%h", cyc, n_results, out_data);
        n_results++;
        last_hs_cyc = cyc;
      end
      if (out_valid)      n_valid_seen++;
      if (arr_process_en) n_step_seen++;
      if (arr_input_en)   check("input_en_only_in_load", in_ready, 1'b1);
      if (done)           n_done++;
    end
  end

  // ---------------- stimulus helpers
  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_results    = 0;
    n_valid_seen = 0;
    n_step_seen  = 0;
    n_stall      = 0;
  endtask

  task automatic start_op(input int n);
    start       = 1'b1;
    num_vectors = CW'(n);
    tick();
    start       = 1'b0;
    $display("[%0d] start num_vectors=%0d", cyc, n);
  endtask

  task automatic load_identity();
    for (int c = 0; c < AW; c++) begin
      logic [AH-1:0][DW-1:0] col;
      int t;
      col      = '0;
      col[c]   = 16'd1;
      in_valid = 1'b1;
      in_data  = col;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("load_ready", in_ready, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_vectors(input int n, input int gap, input bit poke_start);
    for (int i = 0; i < n; i++) begin
      int t;
      w_valid = 1'b1;
      w_data  = vecs[i];
      exp_q.push_back(vecs[i]);
      if (poke_start && i == 1) begin
        start       = 1'b1;
        num_vectors = CW'(9);
      end
      t = 0;
      @(negedge clk);
      while (!w_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("w_accept", w_ready, 1'b1);
      tick();
      start = 1'b0;
      if (gap > 0 && i < n - 1) begin
        w_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("gap_no_step", arr_process_en, 1'b0);
          tick();
        end
      end
    end
    w_valid = 1'b0;
    w_data  = '0;
  endtask

  task automatic wait_done(input int nexp, input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 400) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
    if (done && nexp > 0) check({tag, "_done_after_last"}, cyc, last_hs_cyc + 1);
    check({tag, "_count"}, n_results, nexp);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    tick();
  endtask

  // ---------------- directed sequence
  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    num_vectors = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    w_valid     = 1'b0;
    w_data      = '0;
    out_ready   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < AW; c++) vecs[i][c] = DW'($urandom_range(1, 16'hFFFF));
    end

    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_process_en", arr_process_en, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // basic 4x4, three vectors, no stalls
    clear_counts();
    start_op(3);
    load_identity();
    send_vectors(3, 0, 1'b0);
    wait_done(3, "basic");

    // same vectors with two-cycle gaps
    clear_counts();
    start_op(3);
    load_identity();
    send_vectors(3, 2, 1'b0);
    wait_done(3, "gaps");

    // consumer stalls five cycles while weights are still streaming
    clear_counts();
    start_op(12);
    load_identity();
    stall_arm = 1;
    send_vectors(12, 0, 1'b0);
    wait_done(12, "stall");
    check("stall_cycles", n_stall, 5);

    // zero vectors: load only, then done
    clear_counts();
    start_op(0);
    load_identity();
    @(negedge clk);
    check("nv0_done_after_load", done, 1'b1);
    @(negedge clk);
    check("nv0_done_pulse", done, 1'b0);
    check("nv0_no_valid", n_valid_seen, 0);
    check("nv0_no_step", n_step_seen, 0);
    tick();

    // start during STREAM must not change the job
    clear_counts();
    start_op(3);
    load_identity();
    send_vectors(3, 0, 1'b1);
    wait_done(3, "start_ignored");

    // asynchronous reset in DRAIN
    clear_counts();
    start_op(2);
    load_identity();
    send_vectors(2, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("drain_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_data", out_data, '0);
    check("arst_process_en", arr_process_en, 1'b0);
    check("arst_weight_in", arr_weight_in, '0);
    check("arst_input_en", arr_input_en, 1'b0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    begin
      int done_before;
      done_before = n_done;
      for (int i = 0; i < 20; i++) @(negedge clk);
      check("arst_no_done", n_done, done_before);
      check("arst_no_results", n_results, 0);
      check("arst_idle", busy, 1'b0);
    end
    tick();

    // recovery after reset
    clear_counts();
    start_op(1);
    load_identity();
    send_vectors(1, 0, 1'b0);
    wait_done(1, "recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
